// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode stage: opcode/funct encodings,
// ALU op codes, the reg_dst encoding, the packed control bundle and the
// decode-stage state type.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SYS_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  typedef struct packed {
    logic       jump;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       jump_link;
    logic       jump_reg;
    logic       syscall;
    logic       illegal;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
  } ctrl_t;

endpackage

// File: rtl/mips_decode_comb.sv
// Purely combinational MIPS instruction decoder.
// Ports:
//   instr  - 32-bit instruction word
//   ctrl   - decoded control bundle (all zero except illegal for unknown encodings)
//   rs, rt - source register indices
//   dest   - destination index resolved from reg_dst (rt / rd / 31)
//   imm    - extended immediate (zero-extend for ORI, upper-half for LUI, else sign-extend)
module mips_decode_comb
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [31:0]           instr,
  output ctrl_t                 ctrl,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [DATA_W-1:0]     imm
);

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rd;
  logic [DATA_W-1:0]     imm_sext;
  logic [DATA_W-1:0]     imm_zext;
  logic                  zext_sel;
  logic                  lui_sel;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign rs       = REG_ADDR_W'(instr[25:21]);
  assign rt       = REG_ADDR_W'(instr[20:16]);
  assign rd       = REG_ADDR_W'(instr[15:11]);
  assign imm_sext = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign imm_zext = {{(DATA_W-16){1'b0}}, instr[15:0]};

  always_comb begin
    ctrl     = '0;
    zext_sel = 1'b0;
    lui_sel  = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD, FN_ADDU: begin
            ctrl.reg_dst   = RD_RD;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_ADD;
          end
          FN_SUB: begin
            ctrl.reg_dst   = RD_RD;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_SUB;
          end
          FN_AND: begin
            ctrl.reg_dst   = RD_RD;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_AND;
          end
          FN_OR: begin
            ctrl.reg_dst   = RD_RD;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OR;
          end
          FN_SLT: begin
            ctrl.reg_dst   = RD_RD;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_SLT;
          end
          FN_JR:      ctrl.jump_reg = 1'b1;
          FN_SYSCALL: ctrl.syscall  = 1'b1;
          // Only the all-zero word (canonical NOP) is supported; real shifts are not.
          FN_SLL:     ctrl.illegal  = (instr[25:6] != '0);
          default:    ctrl.illegal  = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_SLTIU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_SLT;
      end
      OP_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OR;
        zext_sel       = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        lui_sel        = 1'b1;
      end
      OP_LW: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
        ctrl.alu_op    = ALU_SUB;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.jump_link = 1'b1;
        ctrl.reg_dst   = RD_R31;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (ctrl.reg_dst)
      RD_RD:   dest = rd;
      RD_R31:  dest = REG_ADDR_W'(31);
      default: dest = rt;
    endcase
  end

  // Shifting the sign-extended value keeps the bits above 31 equal to imm16[15],
  // which is exactly {imm16, 16'b0} sign-extended to DATA_W.
  always_comb begin
    if (lui_sel)       imm = imm_sext << 16;
    else if (zext_sel) imm = imm_zext;
    else               imm = imm_sext;
  end

endmodule

// File: rtl/mips_decode_stage.sv
// Registered decode pipeline stage between fetch and execute.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   if_valid/if_instr     - instruction from fetch; id_ready accepts it
//   id_valid/ex_ready     - decoded instruction offered to execute
//   flush                 - drops the held (and any incoming) instruction
//   ex_mem_read/ex_dest   - load in execute, used for load-use stalls
//   rs, rt, dest, imm     - registered register indices and immediate
//   control outputs       - registered decode controls (see mips_pkg::ctrl_t)
//   sys_req/sys_ack/sys_vreg - syscall handshake; $v0==10 ends in halt
//   halted                - exit syscall completed
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal flow; a held unserviced SYSCALL moves to ST_SYS_WAIT
// ST_SYS_WAIT | sys_req high, waiting for sys_ack or flush
// ST_HALT     | exit syscall done; only rst leaves
module mips_decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  output logic                  id_ready,
  output logic                  id_valid,
  input  logic                  ex_ready,
  input  logic                  flush,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [DATA_W-1:0]     imm,
  output logic [1:0]            reg_dst,
  output logic                  jump,
  output logic                  branch,
  output logic                  branch_ne,
  output logic                  mem_read,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src,
  output logic                  mem_write,
  output logic                  jump_link,
  output logic                  jump_reg,
  output logic                  syscall,
  output logic                  illegal,
  output logic [ALUOP_W-1:0]    alu_op,
  output logic                  sys_req,
  input  logic                  sys_ack,
  input  logic [DATA_W-1:0]     sys_vreg,
  output logic                  halted
);

  localparam logic [DATA_W-1:0] SYS_EXIT = DATA_W'(10);

  ctrl_t                 ctrl_dec, ctrl_d, ctrl_q;
  logic [REG_ADDR_W-1:0] rs_dec, rs_d, rs_q;
  logic [REG_ADDR_W-1:0] rt_dec, rt_d, rt_q;
  logic [REG_ADDR_W-1:0] dest_dec, dest_d, dest_q;
  logic [DATA_W-1:0]     imm_dec, imm_d, imm_q;
  logic                  held_valid_d, held_valid_q;
  logic                  serviced_d, serviced_q;
  state_t                state_d, state_q;
  logic                  hazard;
  logic                  sys_pending;

  mips_decode_comb #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_dec (
    .instr (if_instr),
    .ctrl  (ctrl_dec),
    .rs    (rs_dec),
    .rt    (rt_dec),
    .dest  (dest_dec),
    .imm   (imm_dec)
  );

  assign hazard = held_valid_q && ex_mem_read && (ex_dest != '0) &&
                  ((ex_dest == rs_q) || (ex_dest == rt_q));
  assign sys_pending = ctrl_q.syscall && !serviced_q;
  assign id_valid = held_valid_q && (state_q == ST_RUN) && !hazard && !sys_pending;
  assign id_ready = (state_q == ST_RUN) && (!held_valid_q || (id_valid && ex_ready));

  always_comb begin
    state_d      = state_q;
    held_valid_d = held_valid_q;
    serviced_d   = serviced_q;
    ctrl_d       = ctrl_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    dest_d       = dest_q;
    imm_d        = imm_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          held_valid_d = 1'b0;
        end else if (if_valid && id_ready) begin
          held_valid_d = 1'b1;
          serviced_d   = 1'b0;
          ctrl_d       = ctrl_dec;
          rs_d         = rs_dec;
          rt_d         = rt_dec;
          dest_d       = dest_dec;
          imm_d        = imm_dec;
        end else if (id_valid && ex_ready) begin
          held_valid_d = 1'b0;
        end else if (held_valid_q && sys_pending) begin
          state_d = ST_SYS_WAIT;
        end
      end
      ST_SYS_WAIT: begin
        if (flush) begin
          held_valid_d = 1'b0;
          state_d      = ST_RUN;
        end else if (sys_ack) begin
          if (sys_vreg == SYS_EXIT) begin
            held_valid_d = 1'b0;
            state_d      = ST_HALT;
          end else begin
            serviced_d = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      held_valid_q <= 1'b0;
      serviced_q   <= 1'b0;
      ctrl_q       <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      imm_q        <= '0;
    end else begin
      state_q      <= state_d;
      held_valid_q <= held_valid_d;
      serviced_q   <= serviced_d;
      ctrl_q       <= ctrl_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      imm_q        <= imm_d;
    end
  end

  assign rs         = rs_q;
  assign rt         = rt_q;
  assign dest       = dest_q;
  assign imm        = imm_q;
  assign reg_dst    = ctrl_q.reg_dst;
  assign jump       = ctrl_q.jump;
  assign branch     = ctrl_q.branch;
  assign branch_ne  = ctrl_q.branch_ne;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_write  = ctrl_q.mem_write;
  assign jump_link  = ctrl_q.jump_link;
  assign jump_reg   = ctrl_q.jump_reg;
  assign syscall    = ctrl_q.syscall;
  assign illegal    = ctrl_q.illegal;
  assign alu_op     = ALUOP_W'(ctrl_q.alu_op);
  assign sys_req    = (state_q == ST_SYS_WAIT);
  assign halted     = (state_q == ST_HALT);

endmodule

// File: doc/mips_decode_stage.md
# mips_decode_stage

Registered instruction-decode pipeline stage for the MIPS core. It sits between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and drives registered control fields, register addresses and the extended immediate to execute. It also detects load-use hazards, honours branch flushes, and sequences syscalls through a request/acknowledge handshake that ends in a halt state.

## Interface
- DATA_W, 32, datapath and immediate width (≥32)
- REG_ADDR_W, 5, register-index width
- ALUOP_W, 3, ALU op width; codes: and=000, or=001, add=010, sub=110, slt=111
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents instruction
- if_instr  in  32  instruction word
- id_ready  out  1  stage can accept this cycle
- id_valid  out  1  decoded instruction offered to execute
- ex_ready  in  1  execute accepts
- flush  in  1  kill held instruction (branch/jump taken)
- ex_mem_read, ex_dest  in  1, REG_ADDR_W  load currently in execute and its destination
- rs, rt, dest  out  REG_ADDR_W each  source indices; dest resolved (rt / rd / 31)
- imm  out  DATA_W  extended immediate
- reg_dst  out  2  0=rt, 1=rd, 2=r31
- jump, branch, branch_ne, mem_read, mem_to_reg, reg_write, alu_src, mem_write, jump_link, jump_reg, syscall, illegal  out  1 each
- alu_op  out  ALUOP_W
- sys_req  out  1  syscall request
- sys_ack  in  1  environment completed syscall
- sys_vreg  in  DATA_W  $v0 value, sampled on sys_ack
- halted  out  1  exit syscall completed

## Operation
- Decode opcodes ADDI, ADDIU, ORI, LUI, SLTIU, LW, SW, BEQ, BNE, J, JAL, SPECIAL (funct ADD, ADDU, SUB, AND, OR, SLT, JR, SLL-0 NOP, SYSCALL).
- Control values per class:
  - R-type: reg_dst=1, reg_write=1.
  - I-type ALU: alu_src=1, reg_write=1.
  - LW: mem_read=1, mem_to_reg=1.
  - SW: mem_write=1, reg_write=0.
  - BEQ/BNE: branch=1, alu_op=sub; branch_ne=1 for BNE.
  - JAL: jump=1, jump_link=1, reg_dst=2, reg_write=1.
  - JR: jump_reg=1.
- Immediate extension:
  - ORI: zero-extend.
  - LUI: {imm16, 16'b0} sign-extended to DATA_W, alu_op=add.
  - All others: sign-extend.
- Any unsupported opcode or funct sets illegal=1 with all write/memory/jump controls 0. The instruction still flows downstream.
- State machine RUN / SYS_WAIT / HALT:
  - RUN + held SYSCALL not yet serviced → SYS_WAIT. sys_req=1 from the next cycle.
  - SYS_WAIT + sys_ack, sys_vreg==10 → HALT.
  - SYS_WAIT + sys_ack, any other value → RUN. Mark the instruction serviced; it is then offered with syscall=1.
  - SYS_WAIT + flush → RUN. Drop the instruction; sys_req deasserts.
  - HALT is left only by rst. In HALT, id_ready=0, id_valid=0, halted=1, and flush is ignored.
- Load-use hazard: held valid && ex_mem_read && ex_dest≠0 && (ex_dest==rs || ex_dest==rt). While the hazard holds, id_valid=0 and the instruction is held.
- id_valid = held_valid && state==RUN && !hazard && !(SYSCALL && !serviced).
- id_ready = state==RUN && (!held_valid || (id_valid && ex_ready)).

## Timing
- Latency: one cycle. An instruction accepted at edge N is visible on the outputs after edge N.
- Outputs hold stable while id_valid && !ex_ready.
- flush has priority over acceptance. If flush and if_valid coincide, the incoming instruction is dropped; held_valid=0 next cycle.
- Hazard bubble lasts exactly as long as the ex_* inputs match, normally one cycle.
- Reset values: all outputs 0, state RUN, held_valid 0, serviced 0, id_ready 1 from the first post-reset cycle. Reset mid-SYS_WAIT drops sys_req the next cycle.

## Structure
- Shared package mips_pkg holds the opcode/funct constants, ALU op codes, the reg_dst encoding, and the state typedef.
- Sub-module mips_decode_comb is the purely combinational instr→control/imm/dest decoder. The stage registers its outputs and owns the FSM, hazard logic and handshake.

## Test plan
- 0x20080005 (ADDI) accepted → next cycle alu_op=010, alu_src=1, reg_write=1, dest=8, imm=0x00000005, id_valid=1.
- 0x3508FFFF (ORI) → imm=0x0000FFFF. 0x3C081234 (LUI) → imm=0x12340000, dest=8.
- Load-use: ex_mem_read=1, ex_dest=9 while 0x01285020 (ADD) is held → id_valid=0 for one cycle. With ex_mem_read=0 → id_valid=1, dest=10, reg_dst=1.
- Syscall 0x0000000C with sys_vreg=4 and sys_ack after 3 cycles → sys_req high 3 cycles, then id_valid=1 with syscall=1. Repeat with sys_vreg=10 → halted=1, id_ready=0 until rst.
- flush together with if_valid, and flush during SYS_WAIT → held_valid=0, nothing offered, sys_req=0 next cycle.
- ex_ready held low 4 cycles → outputs stable and id_ready=0. Opcode 0x3F → illegal=1, reg_write=0.
